circuit2_pipe: RTL and testbench
================================

CIRCUIT2_PIPE -- requirements
Module: circuit2_pipe

Interface
REQ-001 Parameter DATAWIDTH, default 32: operand and result width; legal range 8..64.
REQ-002 Parameter SHW, default $clog2(DATAWIDTH): shift-amount width.
REQ-003 clk  input  1: single clock; all state updates on rising edge.
REQ-004 rst  input  1: reset, asynchronous assert, active-low (0 = reset).
REQ-005 a, b, c  input  DATAWIDTH each: operands.
REQ-006 sh_amt  input  SHW: shift amount.
REQ-007 in_valid  input  1: operand set valid.
REQ-008 in_ready  output  1: block accepts an operand set this cycle.
REQ-009 x, z  output  DATAWIDTH each: results.
REQ-010 flags  output  3: {lt, eq, carry_d}.
REQ-011 out_valid  output  1: x, z and flags valid.
REQ-012 out_ready  input  1: consumer accepts the result this cycle.

Function
REQ-013 An input transfer occurs on a rising edge with in_valid=1 and in_ready=1; an output transfer occurs on a rising edge with out_valid=1 and out_ready=1.
REQ-014 Stage 1 registers on an input transfer: d=a+b, e=a+c, f=a-b (all mod 2^DATAWIDTH), carry_d = carry-out of a+b, and sh_amt.
REQ-015 Stage 2 computes from stage-1 registers: lt=(d<e) unsigned, eq=(d==e), g = lt ? e : d, h = eq ? f : g.
REQ-016 Stage 2 computes x = lt ? (g << sh) : g and z = eq ? (h >> sh) : h; both shifts are logical with zero fill, and the result is truncated to DATAWIDTH.
REQ-017 Stage 2 registers x, z and flags into the output register; outputs come only from registers.
REQ-018 Latency: with out_ready held at 1, the result appears with out_valid=1 two rising edges after the input transfer.
REQ-019 Throughput: one transfer per cycle while out_ready=1.
REQ-020 Each stage has a valid bit; a stage loads when it is empty or its contents leave in the same cycle.
REQ-021 in_ready = !s1_valid OR stage-2 can load; stage-2 can load = !out_valid OR out_ready.
REQ-022 Simultaneous output transfer and new stage-2 load in one cycle: no bubble and no loss.
REQ-023 While out_valid=1 and out_ready=0, x, z and flags hold stable.
REQ-024 Results leave in input-acceptance order; no duplication, no drop.
REQ-025 in_valid with in_ready=0: no state change; the source holds its data.
REQ-026 sh_amt=0 passes data through unshifted; sh_amt up to DATAWIDTH-1 is legal.

Reset
REQ-027 While rst=0: s1_valid, out_valid, x, z, flags and all stage-1 registers are 0, asynchronously and without waiting for a clock.
REQ-028 While rst=0: in_ready=0.
REQ-029 Reset mid-operation discards all in-flight operand sets.
REQ-030 The first input transfer is possible on the first rising edge after rst returns to 1.

Verification
REQ-031 W=32, a=5, b=3, c=10, sh=1 -> x=30, z=15, flags=100, out_valid 2 cycles after acceptance.
REQ-032 W=32, a=4, b=6, c=6, sh=2 -> eq: x=10, z=0x3FFFFFFF, flags=010.
REQ-033 W=32, a=0xFFFFFFFF, b=1, c=0, sh=3 -> x=0xFFFFFFF8, z=0xFFFFFFFF, flags=101.
REQ-034 Three back-to-back inputs, out_ready=0 for 4 cycles -> in_ready=0 after 2 accepted, x/z stable; then out_ready=1 -> all three results in order, third accepted on release.
REQ-035 rst=0 asserted between clock edges with 2 results in flight -> out_valid=0, x=z=0 immediately; no stale result after release.
REQ-036 DATAWIDTH=8, a=0x80, b=0x80, c=0x01, sh=7 -> d=0x00, carry_d=1, lt=1, x=0x80, z=0x81.

Source files
------------

// File: rtl/circuit2_pipe.sv
// circuit2_pipe: two-stage valid/ready arithmetic pipeline.
// Stage 1 registers a+b, a+c, a-b, carry and shift; stage 2 selects/shifts.
// Ports: clk, rst (async, active-low); a, b, c, sh_amt, in_valid -> in_ready;
//        x, z, flags {lt,eq,carry_d}, out_valid <- out_ready.
module circuit2_pipe #(
  parameter int DATAWIDTH = 32,
  parameter int SHW       = $clog2(DATAWIDTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATAWIDTH-1:0] a,
  input  logic [DATAWIDTH-1:0] b,
  input  logic [DATAWIDTH-1:0] c,
  input  logic [SHW-1:0]       sh_amt,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [DATAWIDTH-1:0] x,
  output logic [DATAWIDTH-1:0] z,
  output logic [2:0]           flags,
  output logic                 out_valid,
  input  logic                 out_ready
);

  localparam int W = DATAWIDTH;

  logic         s1_valid_q, s1_valid_d;
  logic [W-1:0] d_q, d_d;
  logic [W-1:0] e_q, e_d;
  logic [W-1:0] f_q, f_d;
  logic         carry_q, carry_d;
  logic [SHW-1:0] sh_q, sh_d;

  logic         ov_q, ov_d;
  logic [W-1:0] x_q, x_d;
  logic [W-1:0] z_q, z_d;
  logic [2:0]   flags_q, flags_d;

  logic         s2_load_ok;
  logic         in_fire;
  logic         s1_fire;
  logic         out_fire;
  logic [W:0]   sum_ab;

  logic         lt, eq;
  logic [W-1:0] g, h;

  assign s2_load_ok = !ov_q || out_ready;
  // Reset gates ready so no transfer is advertised while held in reset.
  assign in_ready   = rst && (!s1_valid_q || s2_load_ok);
  assign in_fire    = in_valid && in_ready;
  assign s1_fire    = s1_valid_q && s2_load_ok;
  assign out_fire   = ov_q && out_ready;

  assign sum_ab = {1'b0, a} + {1'b0, b};

  assign lt = d_q < e_q;
  assign eq = d_q == e_q;
  assign g  = lt ? e_q : d_q;
  assign h  = eq ? f_q : g;

  always_comb begin
    s1_valid_d = s1_valid_q;
    d_d        = d_q;
    e_d        = e_q;
    f_d        = f_q;
    carry_d    = carry_q;
    sh_d       = sh_q;
    if (s1_fire)
      s1_valid_d = 1'b0;
    if (in_fire) begin
      s1_valid_d = 1'b1;
      d_d        = sum_ab[W-1:0];
      e_d        = a + c;
      f_d        = a - b;
      carry_d    = sum_ab[W];
      sh_d       = sh_amt;
    end
  end

  always_comb begin
    ov_d    = ov_q;
    x_d     = x_q;
    z_d     = z_q;
    flags_d = flags_q;
    if (out_fire)
      ov_d = 1'b0;
    // A stage-2 load in the same cycle as an output transfer replaces it.
    if (s1_fire) begin
      ov_d    = 1'b1;
      x_d     = lt ? (g << sh_q) : g;
      z_d     = eq ? (h >> sh_q) : h;
      flags_d = {lt, eq, carry_q};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_q <= 1'b0;
      d_q        <= '0;
      e_q        <= '0;
      f_q        <= '0;
      carry_q    <= 1'b0;
      sh_q       <= '0;
      ov_q       <= 1'b0;
      x_q        <= '0;
      z_q        <= '0;
      flags_q    <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      d_q        <= d_d;
      e_q        <= e_d;
      f_q        <= f_d;
      carry_q    <= carry_d;
      sh_q       <= sh_d;
      ov_q       <= ov_d;
      x_q        <= x_d;
      z_q        <= z_d;
      flags_q    <= flags_d;
    end
  end

  assign x         = x_q;
  assign z         = z_q;
  assign flags     = flags_q;
  assign out_valid = ov_q;

endmodule

// File: tb/tb_circuit2_pipe.sv
// tb_circuit2_pipe: directed self-checking bench for circuit2_pipe.
// Covers 32-bit and 8-bit instances with hand-computed vectors.
module tb_circuit2_pipe;

  logic        clk;
  logic        rst;
  logic [31:0] a, b, c;
  logic [4:0]  sh;
  logic        in_valid, out_ready;
  logic        in_ready, out_valid;
  logic [31:0] x, z;
  logic [2:0]  flags;

  logic [7:0]  a8, b8, c8;
  logic [2:0]  sh8;
  logic        in_valid8, out_ready8;
  logic        in_ready8, out_valid8;
  logic [7:0]  x8, z8;
  logic [2:0]  flags8;

  int n_cmp;
  int n_fail;

  circuit2_pipe dut (
    .clk(clk), .rst(rst),
    .a(a), .b(b), .c(c), .sh_amt(sh),
    .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .z(z), .flags(flags),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  circuit2_pipe #(.DATAWIDTH(8)) dut8 (
    .clk(clk), .rst(rst),
    .a(a8), .b(b8), .c(c8), .sh_amt(sh8),
    .in_valid(in_valid8), .in_ready(in_ready8),
    .x(x8), .z(z8), .flags(flags8),
    .out_valid(out_valid8), .out_ready(out_ready8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1 rst = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_valid: out_valid=%b in_ready=%b want 0 0",
               out_valid, in_ready);
    end
    n_cmp++;
    if (x !== 32'd0 || z !== 32'd0 || flags !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_data: x=%h z=%h flags=%b want 0 0 000",
               x, z, flags);
    end
    n_cmp++;
    if (out_valid8 !== 1'b0 || in_ready8 !== 1'b0 || x8 !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_w8: ov=%b ir=%b x=%h want 0 0 00",
               out_valid8, in_ready8, x8);
    end
    tick();
    tick();
    @(negedge clk);
    rst = 1'b1;
    tick();
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release: out_valid=%b in_ready=%b want 0 1",
               out_valid, in_ready);
    end
  endtask

  task automatic test_directed();
    logic [31:0] va[5], vb[5], vc[5], ex[5], ez[5];
    logic [4:0]  vs[5];
    logic [2:0]  ef[5];
    va[0]=32'd5; vb[0]=32'd3; vc[0]=32'd10; vs[0]=5'd1;
    ex[0]=32'd30; ez[0]=32'd15; ef[0]=3'b100;
    va[1]=32'd4; vb[1]=32'd6; vc[1]=32'd6; vs[1]=5'd2;
    ex[1]=32'd10; ez[1]=32'h3FFFFFFF; ef[1]=3'b010;
    va[2]=32'hFFFFFFFF; vb[2]=32'd1; vc[2]=32'd0; vs[2]=5'd3;
    ex[2]=32'hFFFFFFF8; ez[2]=32'hFFFFFFFF; ef[2]=3'b101;
    va[3]=32'd5; vb[3]=32'd3; vc[3]=32'd10; vs[3]=5'd0;
    ex[3]=32'd15; ez[3]=32'd15; ef[3]=3'b100;
    va[4]=32'd5; vb[4]=32'd3; vc[4]=32'd10; vs[4]=5'd31;
    ex[4]=32'h80000000; ez[4]=32'd15; ef[4]=3'b100;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      a = va[i]; b = vb[i]; c = vc[i]; sh = vs[i];
      in_valid = 1'b1;
      n_cmp++;
      if (in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL dir%0d_ready: in_ready=%b want 1", i, in_ready);
      end
      tick();
      in_valid = 1'b0;
      n_cmp++;
      if (out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL dir%0d_early: out_valid=%b want 0", i, out_valid);
      end
      tick();
      n_cmp++;
      if (out_valid !== 1'b1 || x !== ex[i] || z !== ez[i] ||
          flags !== ef[i]) begin
        n_fail++;
        $display("FAIL dir%0d_result: ov=%b x=%h z=%h f=%b want 1 %h %h %b",
                 i, out_valid, x, z, flags, ex[i], ez[i], ef[i]);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] va[3], vb[3], vc[3], ex[3], ez[3];
    logic [4:0]  vs[3];
    logic [2:0]  ef[3];
    int idx;
    va[0]=32'd5; vb[0]=32'd3; vc[0]=32'd10; vs[0]=5'd1;
    ex[0]=32'd30; ez[0]=32'd15; ef[0]=3'b100;
    va[1]=32'd4; vb[1]=32'd6; vc[1]=32'd6; vs[1]=5'd2;
    ex[1]=32'd10; ez[1]=32'h3FFFFFFF; ef[1]=3'b010;
    va[2]=32'hFFFFFFFF; vb[2]=32'd1; vc[2]=32'd0; vs[2]=5'd3;
    ex[2]=32'hFFFFFFF8; ez[2]=32'hFFFFFFFF; ef[2]=3'b101;
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      a = va[i]; b = vb[i]; c = vc[i]; sh = vs[i];
      in_valid = 1'b1;
      tick();
    end
    a = va[2]; b = vb[2]; c = vc[2]; sh = vs[2];
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 ||
          x !== ex[0] || z !== ez[0] || flags !== ef[0]) begin
        n_fail++;
        $display("FAIL b2b_stall%0d: ir=%b ov=%b x=%h z=%h want 0 1 %h %h",
                 k, in_ready, out_valid, x, z, ex[0], ez[0]);
      end
      tick();
    end
    out_ready = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_release_ready: in_ready=%b want 1", in_ready);
    end
    idx = 0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      if (out_valid === 1'b1) begin
        n_cmp++;
        if (idx > 2) begin
          n_fail++;
          $display("FAIL b2b_extra: unexpected result x=%h", x);
        end else if (x !== ex[idx] || z !== ez[idx] ||
                     flags !== ef[idx]) begin
          n_fail++;
          $display("FAIL b2b_out%0d: x=%h z=%h f=%b want %h %h %b",
                   idx, x, z, flags, ex[idx], ez[idx], ef[idx]);
        end
        idx++;
      end
      tick();
      in_valid = 1'b0;
    end
    n_cmp++;
    if (idx != 3) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d results want 3", idx);
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    a = 32'd5; b = 32'd3; c = 32'd10; sh = 5'd1;
    in_valid = 1'b1;
    tick();
    a = 32'd4; b = 32'd6; c = 32'd6; sh = 5'd2;
    tick();
    in_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || x !== 32'd0 || z !== 32'd0 ||
        flags !== 3'b000 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_clear: ov=%b x=%h z=%h f=%b ir=%b want 0 0 0 0 0",
               out_valid, x, z, flags, in_ready);
    end
    tick();
    @(negedge clk);
    rst = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_cmp++;
      if (out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL midrst_stale%0d: out_valid=%b x=%h want 0",
                 k, out_valid, x);
      end
    end
  endtask

  task automatic test_first_after_reset();
    rst = 1'b0;
    #2;
    @(negedge clk);
    rst = 1'b1;
    a = 32'd5; b = 32'd3; c = 32'd10; sh = 5'd1;
    in_valid = 1'b1;
    out_ready = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL first_ready: in_ready=%b want 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    tick();
    n_cmp++;
    if (out_valid !== 1'b1 || x !== 32'd30 || z !== 32'd15) begin
      n_fail++;
      $display("FAIL first_result: ov=%b x=%h z=%h want 1 1e 0f",
               out_valid, x, z);
    end
    tick();
  endtask

  task automatic test_w8();
    a8 = 8'h80; b8 = 8'h80; c8 = 8'h01; sh8 = 3'd7;
    out_ready8 = 1'b1;
    in_valid8 = 1'b1;
    tick();
    in_valid8 = 1'b0;
    tick();
    n_cmp++;
    if (out_valid8 !== 1'b1 || x8 !== 8'h80 || z8 !== 8'h81 ||
        flags8 !== 3'b101) begin
      n_fail++;
      $display("FAIL w8_result: ov=%b x=%h z=%h f=%b want 1 80 81 101",
               out_valid8, x8, z8, flags8);
    end
    tick();
    n_cmp++;
    if (out_valid8 !== 1'b0) begin
      n_fail++;
      $display("FAIL w8_drain: out_valid=%b want 0", out_valid8);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    a = '0; b = '0; c = '0; sh = '0;
    in_valid = 1'b0; out_ready = 1'b0;
    a8 = '0; b8 = '0; c8 = '0; sh8 = '0;
    in_valid8 = 1'b0; out_ready8 = 1'b0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_mid();
    test_first_after_reset();
    test_w8();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
